cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss-handling controller between the pipelined CPU's I-cache/D-cache and the shared 4-cycle pipelined main memory.
- On an I or D cache miss it fetches the full 16-byte block (8 x 16-bit words) from memory.
- Streams each returned word into the missing cache's data array, then writes the tag.
- Signals completion so the stalled fetch or memory stage can resume.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; power of two.
- OFFSET_BITS, 3, log2(WORDS_PER_BLOCK); word-index width.
- MEM_LATENCY, 4, cycles from a mem_en request to its mem_data_valid; used only for the post-reset drain.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- i_miss  input  1  I-cache miss; held high until i_fill_done.
- i_miss_addr  input  16  byte address of the I-cache miss.
- d_miss  input  1  D-cache miss; held high until d_fill_done.
- d_miss_addr  input  16  byte address of the D-cache miss.
- mem_data_valid  input  1  memory read data valid this cycle.
- mem_data  input  16  memory read data.
- mem_en  output  1  memory read request this cycle.
- mem_addr  output  16  word-aligned request address.
- fill_data  output  16  word to write into the cache data array; equals mem_data.
- fill_word  output  3  word index within the block for fill_data.
- i_data_we  output  1  I-cache data array write enable.
- d_data_we  output  1  D-cache data array write enable.
- i_tag_we  output  1  I-cache tag/valid write enable.
- d_tag_we  output  1  D-cache tag/valid write enable.
- i_fill_done  output  1  one-cycle pulse: I fill complete.
- d_fill_done  output  1  one-cycle pulse: D fill complete.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: DRAIN, IDLE, FILL, WAIT, DONE.
- Reset:
  - Enter DRAIN with drain_cnt=0, issue_cnt=0, recv_cnt=0.
  - All enables and done pulses are 0; mem_addr=0; busy=1.
  - Reset mid-fill aborts the fill with no tag write and no done pulse.
- DRAIN:
  - Ignore mem_data_valid for MEM_LATENCY cycles after rst deasserts.
  - Then go to IDLE. In-flight pre-reset responses are never written.
- IDLE:
  - d_miss has priority over i_miss.
  - On the accepting edge, latch base = {miss_addr[15:4], 4'b0}, latch target (D or I), clear both counters, go to FILL.
  - Both misses high at once: D is served first; I stays pending and is accepted in the first IDLE cycle after D's DONE.
- FILL:
  - mem_en=1, mem_addr = base + {issue_cnt, 1'b0}; issue_cnt increments each cycle.
  - After issue_cnt=7 is issued, go to WAIT.
  - Exactly 8 requests are issued, on consecutive cycles, with no gaps.
- Receive (FILL or WAIT):
  - Each mem_data_valid drives fill_data=mem_data, fill_word=recv_cnt, and the target's data_we=1 combinationally.
  - recv_cnt increments on that edge.
  - When recv_cnt==7 and mem_data_valid=1, the target's tag_we=1 in the same cycle, and the next state is DONE.
- Valid outside FILL/WAIT, or beyond 8 words: ignored; no write enables.
- DONE:
  - Target's fill_done=1 for exactly one cycle; busy=1.
  - Next state IDLE.
  - A miss still high during DONE is not accepted that cycle.
- Timing:
  - Miss seen in IDLE at cycle T: requests at T+1..T+8.
  - Data at T+1+MEM_LATENCY..T+8+MEM_LATENCY.
  - Done pulse at T+9+MEM_LATENCY (cycle 13 after acceptance for default parameters).
- Miss inputs and addresses are sampled only in IDLE; changes during a fill are ignored.
- Never more than one of i_* / d_* enables active in the same cycle.
- mem_addr bit 0 is always 0; the address increment wraps only within the block.

Test Plan:
- Reset 3 cycles, release:
  - busy=1 for 4 cycles, then 0.
  - All enables 0; no mem_en during drain.
- i_miss with i_miss_addr=0x123A, memory returning 0xA000+index:
  - mem_addr 0x1230,0x1232,...,0x123E on 8 consecutive cycles.
  - i_data_we with fill_word 0..7, data 0xA000..0xA007.
  - i_tag_we on the 8th word; i_fill_done exactly 13 cycles after acceptance; d_* never asserted.
- d_miss=0x4006 and i_miss=0x0010 raised the same cycle:
  - D block 0x4000-0x400E filled first, then d_fill_done.
  - The next IDLE cycle accepts I at 0x0010; i_fill_done follows 13 cycles later.
- Stray mem_data_valid pulses injected in IDLE and after 8 words received -> no data_we/tag_we, counters unchanged.
- rst asserted during WAIT after 5 words received:
  - No tag_we or done pulse.
  - Responses still arriving within the 4 drain cycles produce no writes.
  - A fresh miss afterward completes normally.
- Back-to-back D misses 0xFFF0 then 0x0000:
  - Second fill's addresses are 0x0000..0x000E.
  - The first fill's addresses stop at 0xFFFE with no carry into the next block.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - I/D cache miss block-fill controller
//
// Fetches a whole cache block from the shared pipelined memory when the
// I-cache or D-cache misses, streams each returned word into the missing
// cache's data array, writes the tag with the last word, then pulses done.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   i_miss, i_miss_addr      I-cache miss request and byte address
//   d_miss, d_miss_addr      D-cache miss request and byte address (wins ties)
//   mem_data_valid, mem_data memory read response
//   mem_en, mem_addr         memory read request, word-aligned address
//   fill_data, fill_word     word and in-block index to write into the cache
//   i_data_we, d_data_we     data array write enables
//   i_tag_we, d_tag_we       tag/valid write enables (with the last word)
//   i_fill_done, d_fill_done one-cycle completion pulses
//   busy                     high whenever the controller is not idle
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int OFFSET_BITS     = 3,
  parameter int MEM_LATENCY     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_data_we,
  output logic        d_data_we,
  output logic        i_tag_we,
  output logic        d_tag_we,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        busy
);

  localparam int HI_W    = 16 - OFFSET_BITS - 1;
  localparam int DRAIN_W = $clog2(MEM_LATENCY + 1);
  localparam logic [OFFSET_BITS-1:0] LAST_WORD  = OFFSET_BITS'(WORDS_PER_BLOCK - 1);
  localparam logic [DRAIN_W-1:0]     DRAIN_LAST = DRAIN_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_FILL, S_WAIT, S_DONE} fillState_t;

  fillState_t             state, nextState;
  logic [DRAIN_W-1:0]     drainCnt;
  logic [OFFSET_BITS-1:0] issueCnt;
  logic [OFFSET_BITS-1:0] recvCnt;
  logic [HI_W-1:0]        baseHi;
  logic                   targetD;
  logic                   missSeen;
  logic                   recvFire;
  logic                   lastRecv;
  logic                   unusedAddrBits;

  // Only the block number of a miss address matters; the offset is dropped.
  assign unusedAddrBits = ^{i_miss_addr[OFFSET_BITS:0], d_miss_addr[OFFSET_BITS:0]};

  assign missSeen = d_miss | i_miss;
  assign recvFire = ((state == S_FILL) || (state == S_WAIT)) && mem_data_valid;
  assign lastRecv = recvFire && (recvCnt == LAST_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_DRAIN;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drainCnt <= '0;
      issueCnt <= '0;
      recvCnt  <= '0;
      baseHi   <= '0;
      targetD  <= 1'b0;
    end else begin
      if (state == S_DRAIN) begin
        drainCnt <= drainCnt + 1'b1;
      end
      if ((state == S_IDLE) && missSeen) begin
        targetD  <= d_miss;
        baseHi   <= d_miss ? d_miss_addr[15:OFFSET_BITS+1] : i_miss_addr[15:OFFSET_BITS+1];
        issueCnt <= '0;
        recvCnt  <= '0;
      end
      if (state == S_FILL) begin
        issueCnt <= issueCnt + 1'b1;
      end
      if (recvFire) begin
        recvCnt <= recvCnt + 1'b1;
      end
    end
  end

  always_comb begin
    nextState   = state;
    mem_en      = 1'b0;
    mem_addr    = '0;
    fill_data   = mem_data;
    fill_word   = recvCnt;
    i_data_we   = 1'b0;
    d_data_we   = 1'b0;
    i_tag_we    = 1'b0;
    d_tag_we    = 1'b0;
    i_fill_done = 1'b0;
    d_fill_done = 1'b0;
    busy        = (state != S_IDLE);

    case (state)
      S_DRAIN: begin
        // Responses to requests issued before reset land here and are dropped.
        if (drainCnt == DRAIN_LAST) begin
          nextState = S_IDLE;
        end
      end
      S_IDLE: begin
        if (missSeen) begin
          nextState = S_FILL;
        end
      end
      S_FILL: begin
        mem_en   = 1'b1;
        // Offset is spliced in rather than added so the walk never carries
        // out of the block.
        mem_addr = {baseHi, issueCnt, 1'b0};
        if (issueCnt == LAST_WORD) begin
          nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        nextState = S_WAIT;
      end
      S_DONE: begin
        i_fill_done = ~targetD;
        d_fill_done = targetD;
        nextState   = S_IDLE;
      end
      default: begin
        nextState = S_DRAIN;
      end
    endcase

    if (recvFire) begin
      i_data_we = ~targetD;
      d_data_we = targetD;
    end
    if (lastRecv) begin
      i_tag_we  = ~targetD;
      d_tag_we  = targetD;
      nextState = S_DONE;
    end

    // While reset is held nothing may reach the caches, even in the cycle
    // where reset rises over a fill that is still in progress.
    if (rst) begin
      mem_en      = 1'b0;
      mem_addr    = '0;
      i_data_we   = 1'b0;
      d_data_we   = 1'b0;
      i_tag_we    = 1'b0;
      d_tag_we    = 1'b0;
      i_fill_done = 1'b0;
      d_fill_done = 1'b0;
      busy        = 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - bench for cache_fill_fsm
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_miss = 1'b0;
  logic [15:0] i_miss_addr = '0;
  logic        d_miss = 1'b0;
  logic [15:0] d_miss_addr = '0;
  logic        mem_data_valid = 1'b0;
  logic [15:0] mem_data = '0;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_data_we, d_data_we, i_tag_we, d_tag_we;
  logic        i_fill_done, d_fill_done, busy;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk(clk), .rst(rst),
    .i_miss(i_miss), .i_miss_addr(i_miss_addr),
    .d_miss(d_miss), .d_miss_addr(d_miss_addr),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .fill_data(fill_data), .fill_word(fill_word),
    .i_data_we(i_data_we), .d_data_we(d_data_we),
    .i_tag_we(i_tag_we), .d_tag_we(d_tag_we),
    .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a timeline per fill. mode 0 = draining, 1 = idle,
  // 2 = filling (requests at offsets 1..8 from acceptance, done the cycle
  // after the eighth word is taken).
  int          cyc = 0;
  int          mode = 0;
  int          drainLeft = 4;
  int          tStart = 0;
  bit          tgtD = 1'b0;
  logic [15:0] base = '0;
  int          recvd = 0;
  int          lastAccept = 0;
  int          lastIDone = -1;
  int          lastDDone = -1;
  bit          dataIndexed = 1'b0;
  bit          strayOn = 1'b0;

  typedef struct {int due; logic [15:0] data;} resp_t;
  resp_t respQ[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic expBusy, expEn, expIWe, expDWe, expITag, expDTag, expIDone, expDDone;
    logic [15:0] expAddr;
    int k, expWord;
    bit wr, realResp;
    resp_t r;

    realResp = 1'b0;
    mem_data_valid = 1'b0;
    mem_data = 16'($urandom);
    if (respQ.size() > 0 && respQ[0].due == cyc) begin
      realResp = 1'b1;
      mem_data_valid = 1'b1;
      mem_data = respQ[0].data;
      respQ.delete(0);
    end
    if (!realResp && strayOn && !rst && (mode != 2 || recvd == 8) && ($urandom_range(0, 1) == 1)) begin
      mem_data_valid = 1'b1;
    end
    #1;

    expBusy = 1'b1; expEn = 1'b0; expAddr = '0;
    expIWe = 1'b0; expDWe = 1'b0; expITag = 1'b0; expDTag = 1'b0;
    expIDone = 1'b0; expDDone = 1'b0;
    wr = 1'b0; expWord = 0; k = 0;
    if (!rst) begin
      if (mode == 1) begin
        expBusy = 1'b0;
      end else if (mode == 2) begin
        k = cyc - tStart;
        if (k <= 8) begin
          expEn = 1'b1;
          expAddr = base + 16'(2 * (k - 1));
        end
        if (recvd == 8) begin
          expIDone = !tgtD;
          expDDone = tgtD;
        end else if (mem_data_valid) begin
          wr = 1'b1;
          expWord = recvd;
          expIWe = !tgtD;
          expDWe = tgtD;
          expITag = !tgtD && (recvd == 7);
          expDTag = tgtD && (recvd == 7);
        end
      end
    end

    check("busy", 32'(busy), 32'(expBusy));
    check("mem_en", 32'(mem_en), 32'(expEn));
    if (expEn || rst) check("mem_addr", 32'(mem_addr), 32'(expAddr));
    check("i_data_we", 32'(i_data_we), 32'(expIWe));
    check("d_data_we", 32'(d_data_we), 32'(expDWe));
    check("i_tag_we", 32'(i_tag_we), 32'(expITag));
    check("d_tag_we", 32'(d_tag_we), 32'(expDTag));
    check("i_fill_done", 32'(i_fill_done), 32'(expIDone));
    check("d_fill_done", 32'(d_fill_done), 32'(expDDone));
    if (wr) begin
      check("fill_word", 32'(fill_word), 32'(expWord));
      check("fill_data", 32'(fill_data), 32'(mem_data));
    end
    if (i_fill_done === 1'b1) lastIDone = cyc;
    if (d_fill_done === 1'b1) lastDDone = cyc;

    // Memory answers whatever the DUT actually requested, MEM_LATENCY later.
    if (mem_en === 1'b1) begin
      r.due = cyc + 4;
      r.data = dataIndexed ? (16'hA000 + 16'((mem_addr >> 1) & 16'd7)) : 16'($urandom);
      respQ.push_back(r);
    end

    if (rst) begin
      mode = 0;
      drainLeft = 4;
    end else if (mode == 0) begin
      drainLeft--;
      if (drainLeft == 0) mode = 1;
    end else if (mode == 1) begin
      if (d_miss || i_miss) begin
        mode = 2;
        tStart = cyc;
        lastAccept = cyc;
        tgtD = d_miss;
        base = (d_miss ? d_miss_addr : i_miss_addr) & 16'hFFF0;
        recvd = 0;
      end
    end else begin
      if (recvd == 8) begin
        mode = 1;
        if (tgtD) d_miss = 1'b0;
        else i_miss = 1'b0;
      end else if (wr) begin
        recvd++;
      end
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runUntilIdle(input int budget, input string tag);
    int n;
    n = 0;
    cycle();
    while (!(mode == 1 && !i_miss && !d_miss) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    int sel;

    // Reset held three cycles, then four drain cycles with stray valids.
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    strayOn = 1'b1;
    repeat (4) cycle();
    cycle();
    strayOn = 1'b0;

    // Single I fill with indexed data.
    dataIndexed = 1'b1;
    i_miss = 1'b1;
    i_miss_addr = 16'h123A;
    runUntilIdle(40, "i_fill");
    check("i_latency", 32'(lastIDone - lastAccept), 32'd13);
    dataIndexed = 1'b0;

    // Simultaneous misses: D first, I accepted right after D's done.
    d_miss = 1'b1; d_miss_addr = 16'h4006;
    i_miss = 1'b1; i_miss_addr = 16'h0010;
    runUntilIdle(60, "d_then_i");
    check("d_then_i_gap", 32'(lastIDone - lastDDone), 32'd14);

    // Stray valids in idle and in the done cycle of a fill.
    strayOn = 1'b1;
    repeat (6) cycle();
    d_miss = 1'b1; d_miss_addr = 16'h7A5C;
    runUntilIdle(40, "stray_fill");
    repeat (4) cycle();
    strayOn = 1'b0;

    // Reset while waiting for data after five words.
    n = 0;
    d_miss = 1'b1; d_miss_addr = 16'($urandom);
    while (!(mode == 2 && recvd == 5) && n < 30) begin
      cycle();
      n++;
    end
    check("reach_five_words", 32'(n < 30), 32'd1);
    d_miss = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    runUntilIdle(10, "mid_reset_drain");
    i_miss = 1'b1; i_miss_addr = 16'($urandom);
    runUntilIdle(40, "after_reset");
    check("after_reset_latency", 32'(lastIDone - lastAccept), 32'd13);

    // Back-to-back D misses at the top and bottom of the address space.
    d_miss = 1'b1; d_miss_addr = 16'hFFF0;
    runUntilIdle(40, "d_top");
    d_miss = 1'b1; d_miss_addr = 16'h0000;
    runUntilIdle(40, "d_bottom");
    check("d_bottom_latency", 32'(lastDDone - lastAccept), 32'd13);

    // Randomized misses, gaps and stray valids.
    for (int r = 0; r < 8; r++) begin
      sel = $urandom_range(0, 2);
      strayOn = ($urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) cycle();
      d_miss = (sel != 0); d_miss_addr = 16'($urandom);
      i_miss = (sel != 1); i_miss_addr = 16'($urandom);
      runUntilIdle(80, "rand_fill");
    end
    strayOn = 1'b0;
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
